// File: rtl/stream_checker_pkg.sv
// Shared types and PRBS-8 helpers for the stream checker and any matching stimulus source.
package stream_checker_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Feedback taps on bits 7, 5, 4 and 3.
  localparam logic [7:0] PRBS8_TAPS = 8'hB8;

  function automatic logic [7:0] prbs8_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & PRBS8_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  function automatic logic [7:0] seed_fixup(input logic [7:0] seed);
    return (seed == 8'h00) ? 8'h01 : seed;
  endfunction

endpackage

// File: rtl/prbs8_gen.sv
// PRBS-8 generator: load takes the (fixed-up) seed, advance steps one word.
module prbs8_gen
  import stream_checker_pkg::*;
(
  input  logic       clk_i,
  input  logic       srst,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] seed,
  output logic [7:0] value
);

  logic [7:0] value_reg;
  logic [7:0] value_next;

  always_comb begin
    value_next = value_reg;
    if (load) begin
      value_next = seed_fixup(seed);
    end else if (advance) begin
      value_next = prbs8_next(value_reg);
    end
  end

  always_ff @(posedge clk_i) begin
    if (srst) begin
      value_reg <= seed_fixup(seed);
    end else begin
      value_reg <= value_next;
    end
  end

  assign value = value_reg;

endmodule

// File: rtl/stream_checker.sv
// Checks a valid/ready word stream against PRBS-8 and reports pass/fail and error stats.
// Optional idle watchdog is built when STREAM_CHECKER_TIMEOUT_EN is defined.
module stream_checker
  import stream_checker_pkg::*;
#(
  parameter int         P_WORDS   = 16,
  parameter logic [7:0] P_SEED    = 8'h55,
  parameter int         P_TIMEOUT = 1024
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic       START_I,
  input  logic [7:0] DATA_I,
  input  logic       VALID_I,
  output logic       READY_O,
  output logic       BUSY_O,
  output logic       DONE_O,
  output logic       PASS_O,
  output logic [7:0] ERR_CNT_O,
  output logic [7:0] FIRST_ERR_O,
  output logic       TIMEOUT_O
);

  localparam logic [7:0] LAST_IDX = 8'(P_WORDS - 1);

  if (P_WORDS < 1 || P_WORDS > 255 || P_TIMEOUT < 1) begin : g_param_check
    $error("stream_checker: P_WORDS must be 1..255 and P_TIMEOUT at least 1");
  end

  state_t     state_reg, state_next;
  logic [7:0] word_cnt_reg, word_cnt_next;
  logic [7:0] err_cnt_reg, err_cnt_next;
  logic [7:0] first_err_reg, first_err_next;
  logic       pass_reg, pass_next;
  logic       ready_reg, busy_reg, done_reg;
  logic       mismatch;
  logic       prbs_load, prbs_adv;
  logic [7:0] expected;

`ifdef STREAM_CHECKER_TIMEOUT_EN
  localparam int WD_W = $clog2(P_TIMEOUT + 1);
  logic            timeout_reg, timeout_next;
  logic [WD_W-1:0] wdog_reg, wdog_next;
`endif

  prbs8_gen u_prbs (
    .clk_i   (CLK_I),
    .srst    (RST_I),
    .load    (prbs_load),
    .advance (prbs_adv),
    .seed    (P_SEED),
    .value   (expected)
  );

  always_comb begin
    state_next     = state_reg;
    word_cnt_next  = word_cnt_reg;
    err_cnt_next   = err_cnt_reg;
    first_err_next = first_err_reg;
    pass_next      = pass_reg;
    mismatch       = 1'b0;
    prbs_load      = 1'b0;
    prbs_adv       = 1'b0;
`ifdef STREAM_CHECKER_TIMEOUT_EN
    timeout_next   = timeout_reg;
    wdog_next      = wdog_reg;
`endif
    case (state_reg)
      ST_IDLE, ST_DONE: begin
        if (START_I) begin
          state_next     = ST_RUN;
          word_cnt_next  = 8'h00;
          err_cnt_next   = 8'h00;
          first_err_next = 8'hFF;
          pass_next      = 1'b0;
          prbs_load      = 1'b1;
`ifdef STREAM_CHECKER_TIMEOUT_EN
          timeout_next   = 1'b0;
          wdog_next      = '0;
`endif
        end
      end
      ST_RUN: begin
        if (VALID_I) begin
          prbs_adv      = 1'b1;
          word_cnt_next = word_cnt_reg + 8'd1;
          mismatch      = (DATA_I != expected);
          if (mismatch) begin
            if (err_cnt_reg != 8'hFF) err_cnt_next = err_cnt_reg + 8'd1;
            // Error count is still zero only before the first mismatch of the run.
            if (err_cnt_reg == 8'h00) first_err_next = word_cnt_reg;
          end
`ifdef STREAM_CHECKER_TIMEOUT_EN
          wdog_next = '0;
`endif
          if (word_cnt_reg == LAST_IDX) begin
            state_next = ST_DONE;
            pass_next  = (err_cnt_next == 8'h00);
          end
        end
`ifdef STREAM_CHECKER_TIMEOUT_EN
        else if (wdog_reg == WD_W'(P_TIMEOUT - 1)) begin
          state_next   = ST_DONE;
          timeout_next = 1'b1;
          pass_next    = 1'b0;
        end else begin
          wdog_next = wdog_reg + WD_W'(1);
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_reg     <= ST_IDLE;
      word_cnt_reg  <= 8'h00;
      err_cnt_reg   <= 8'h00;
      first_err_reg <= 8'hFF;
      pass_reg      <= 1'b0;
      ready_reg     <= 1'b0;
      busy_reg      <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      word_cnt_reg  <= word_cnt_next;
      err_cnt_reg   <= err_cnt_next;
      first_err_reg <= first_err_next;
      pass_reg      <= pass_next;
      ready_reg     <= (state_next == ST_RUN);
      busy_reg      <= (state_next == ST_RUN);
      done_reg      <= (state_next == ST_DONE);
    end
  end

`ifdef STREAM_CHECKER_TIMEOUT_EN
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      timeout_reg <= 1'b0;
      wdog_reg    <= '0;
    end else begin
      timeout_reg <= timeout_next;
      wdog_reg    <= wdog_next;
    end
  end

  assign TIMEOUT_O = timeout_reg;
`else
  assign TIMEOUT_O = 1'b0;
`endif

  assign READY_O     = ready_reg;
  assign BUSY_O      = busy_reg;
  assign DONE_O      = done_reg;
  assign PASS_O      = pass_reg;
  assign ERR_CNT_O   = err_cnt_reg;
  assign FIRST_ERR_O = first_err_reg;

endmodule

// File: tb/tb_stream_checker.sv
// Scoreboard bench for stream_checker: a 4-word instance and a 255-word instance share the clock.
module tb_stream_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       a_start, a_valid, b_start, b_valid;
  logic [7:0] a_data, b_data;
  logic       a_ready, a_busy, a_done, a_pass, a_timeout;
  logic       b_ready, b_busy, b_done, b_pass, b_timeout;
  logic [7:0] a_err, a_first, b_err, b_first;

  stream_checker #(.P_WORDS(4), .P_SEED(8'h55), .P_TIMEOUT(8)) dut_a (
    .CLK_I(clk), .RST_I(rst), .START_I(a_start), .DATA_I(a_data), .VALID_I(a_valid),
    .READY_O(a_ready), .BUSY_O(a_busy), .DONE_O(a_done), .PASS_O(a_pass),
    .ERR_CNT_O(a_err), .FIRST_ERR_O(a_first), .TIMEOUT_O(a_timeout)
  );

  stream_checker #(.P_WORDS(255), .P_SEED(8'h55), .P_TIMEOUT(1024)) dut_b (
    .CLK_I(clk), .RST_I(rst), .START_I(b_start), .DATA_I(b_data), .VALID_I(b_valid),
    .READY_O(b_ready), .BUSY_O(b_busy), .DONE_O(b_done), .PASS_O(b_pass),
    .ERR_CNT_O(b_err), .FIRST_ERR_O(b_first), .TIMEOUT_O(b_timeout)
  );

  typedef struct {
    logic [7:0] err;
    logic [7:0] first;
    logic [7:0] data;
    int         idx;
  } exp_t;

  exp_t       sb_q[$];
  int         checks = 0;
  int         failures = 0;
  logic [7:0] m_exp, m_err, m_first;
  int         m_idx;

  function automatic logic [7:0] model_next(input logic [7:0] v);
    return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start();
    m_exp   = 8'h55;
    m_err   = 8'h00;
    m_first = 8'hFF;
    m_idx   = 0;
    sb_q.delete();
  endtask

  task automatic model_push(input logic [7:0] d);
    exp_t e;
    if (d !== m_exp) begin
      if (m_err != 8'hFF) m_err = m_err + 8'd1;
      if (m_first == 8'hFF) m_first = m_idx[7:0];
    end
    e.err   = m_err;
    e.first = m_first;
    e.data  = d;
    e.idx   = m_idx;
    sb_q.push_back(e);
    m_exp = model_next(m_exp);
    m_idx++;
  endtask

  task automatic a_send(input logic [7:0] d);
    exp_t e;
    a_valid = 1'b1;
    a_data  = d;
    model_push(d);
    step();
    e = sb_q.pop_front();
    checks++;
    if (a_err !== e.err) begin
      failures++;
      $display("FAIL a_err_cnt word %0d: got %0d want %0d", e.idx, a_err, e.err);
    end
    checks++;
    if (a_first !== e.first) begin
      failures++;
      $display("FAIL a_first_err word %0d: got %02h want %02h", e.idx, a_first, e.first);
    end
    $display("a word %0d data=%02h err=%0d first=%02h", e.idx, e.data, a_err, a_first);
  endtask

  task automatic b_send(input logic [7:0] d);
    exp_t e;
    b_valid = 1'b1;
    b_data  = d;
    model_push(d);
    step();
    e = sb_q.pop_front();
    checks++;
    if (b_err !== e.err) begin
      failures++;
      $display("FAIL b_err_cnt word %0d: got %0d want %0d", e.idx, b_err, e.err);
    end
    checks++;
    if (b_first !== e.first) begin
      failures++;
      $display("FAIL b_first_err word %0d: got %02h want %02h", e.idx, b_first, e.first);
    end
    $display("b word %0d data=%02h err=%0d first=%02h", e.idx, e.data, b_err, b_first);
  endtask

  task automatic a_start_run();
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    model_start();
    checks++;
    if ({a_ready, a_busy, a_done, a_err, a_first} !== {3'b110, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL a_start rdy/busy/done/err/first: got %b/%b/%b/%02h/%02h want 1/1/0/00/ff",
               a_ready, a_busy, a_done, a_err, a_first);
    end
    $display("a start ready=%b busy=%b", a_ready, a_busy);
  endtask

  task automatic b_start_run();
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    model_start();
    checks++;
    if ({b_ready, b_busy, b_done, b_err, b_first} !== {3'b110, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL b_start rdy/busy/done/err/first: got %b/%b/%b/%02h/%02h want 1/1/0/00/ff",
               b_ready, b_busy, b_done, b_err, b_first);
    end
    $display("b start ready=%b busy=%b", b_ready, b_busy);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    step();
    checks++;
    if ({a_ready, a_busy, a_done, a_pass, a_timeout, a_err, a_first} !== {5'b0, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL reset_a: got %b%b%b%b%b err=%02h first=%02h want 00000 err=00 first=ff",
               a_ready, a_busy, a_done, a_pass, a_timeout, a_err, a_first);
    end
    checks++;
    if ({b_ready, b_busy, b_done, b_pass, b_timeout, b_err, b_first} !== {5'b0, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL reset_b: got %b%b%b%b%b err=%02h first=%02h want 00000 err=00 first=ff",
               b_ready, b_busy, b_done, b_pass, b_timeout, b_err, b_first);
    end
    $display("reset done");
  endtask

  task automatic test_clean();
    a_start_run();
    a_send(8'h55);
    a_send(8'hAB);
    a_send(8'h57);
    a_send(8'hAF);
    a_valid = 1'b0;
    checks++;
    if ({a_done, a_pass, a_ready, a_err, a_first} !== {3'b110, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL clean_result done/pass/ready/err/first: got %b/%b/%b/%02h/%02h want 1/1/0/00/ff",
               a_done, a_pass, a_ready, a_err, a_first);
    end
    $display("clean run done=%b pass=%b", a_done, a_pass);
  endtask

  task automatic test_gaps();
    a_start_run();
    a_send(8'h55);
    a_send(8'hAB);
    a_valid = 1'b0;
    a_data  = 8'h57;
    step();
    step();
    checks++;
    if ({a_busy, a_err} !== {1'b1, 8'h00}) begin
      failures++;
      $display("FAIL gap_idle busy/err: got %b/%02h want 1/00", a_busy, a_err);
    end
    a_send(8'h00);
    a_send(8'hAF);
    a_valid = 1'b0;
    checks++;
    if ({a_done, a_pass, a_err, a_first} !== {2'b10, 8'h01, 8'h02}) begin
      failures++;
      $display("FAIL gap_result done/pass/err/first: got %b/%b/%02h/%02h want 1/0/01/02",
               a_done, a_pass, a_err, a_first);
    end
    $display("gap run err=%0d first=%0d", a_err, a_first);
  endtask

  task automatic test_ignored();
    rst = 1'b1;
    step();
    rst = 1'b0;
    a_valid = 1'b1;
    a_data  = 8'h55;
    repeat (3) step();
    a_valid = 1'b0;
    checks++;
    if ({a_ready, a_busy, a_done} !== 3'b000) begin
      failures++;
      $display("FAIL idle_valid rdy/busy/done: got %b%b%b want 000", a_ready, a_busy, a_done);
    end
    a_start_run();
    a_send(8'h55);
    a_start = 1'b1;
    a_send(8'hAB);
    a_start = 1'b0;
    a_send(8'h57);
    a_send(8'hAF);
    a_valid = 1'b0;
    checks++;
    if ({a_done, a_pass, a_err, a_first} !== {2'b11, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL ignored_result done/pass/err/first: got %b/%b/%02h/%02h want 1/1/00/ff",
               a_done, a_pass, a_err, a_first);
    end
    $display("ignored-inputs run pass=%b", a_pass);
  endtask

  task automatic test_reset_mid_run();
    a_start_run();
    a_send(8'h55);
    a_send(8'h00);
    a_valid = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if ({a_ready, a_busy, a_done, a_err, a_first} !== {3'b000, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL midrun_reset rdy/busy/done/err/first: got %b/%b/%b/%02h/%02h want 0/0/0/00/ff",
               a_ready, a_busy, a_done, a_err, a_first);
    end
    rst = 1'b1;
    a_start = 1'b1;
    step();
    rst = 1'b0;
    a_start = 1'b0;
    checks++;
    if ({a_ready, a_busy} !== 2'b00) begin
      failures++;
      $display("FAIL reset_beats_start rdy/busy: got %b%b want 00", a_ready, a_busy);
    end
    a_start_run();
    a_send(8'h55);
    a_send(8'hAB);
    a_send(8'h57);
    a_send(8'hAF);
    a_valid = 1'b0;
    checks++;
    if ({a_done, a_pass} !== 2'b11) begin
      failures++;
      $display("FAIL restart_after_reset done/pass: got %b%b want 11", a_done, a_pass);
    end
    $display("reset mid-run then restart pass=%b", a_pass);
  endtask

  task automatic test_saturation();
    b_start_run();
    for (int i = 0; i < 255; i++) b_send(8'h00);
    b_valid = 1'b0;
    checks++;
    if ({b_done, b_pass, b_err, b_first} !== {2'b10, 8'hFF, 8'h00}) begin
      failures++;
      $display("FAIL saturation done/pass/err/first: got %b/%b/%02h/%02h want 1/0/ff/00",
               b_done, b_pass, b_err, b_first);
    end
    b_start_run();
    for (int i = 0; i < 255; i++) b_send(m_exp);
    b_valid = 1'b0;
    checks++;
    if ({b_done, b_pass, b_err, b_first} !== {2'b11, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL clean_255 done/pass/err/first: got %b/%b/%02h/%02h want 1/1/00/ff",
               b_done, b_pass, b_err, b_first);
    end
    $display("saturation then clean 255-word run pass=%b", b_pass);
  endtask

  task automatic test_timeout();
    int n;
    a_start_run();
    a_send(8'h55);
    a_valid = 1'b0;
`ifdef STREAM_CHECKER_TIMEOUT_EN
    n = 0;
    while (a_done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (n != 8) begin
      failures++;
      $display("FAIL timeout_latency idle cycles: got %0d want 8", n);
    end
    checks++;
    if ({a_done, a_timeout, a_pass, a_ready, a_err, a_first} !== {4'b1100, 8'h00, 8'hFF}) begin
      failures++;
      $display("FAIL timeout_result done/to/pass/rdy/err/first: got %b/%b/%b/%b/%02h/%02h want 1/1/0/0/00/ff",
               a_done, a_timeout, a_pass, a_ready, a_err, a_first);
    end
    $display("timeout after %0d idle cycles", n);
`else
    n = 20;
    repeat (n) step();
    checks++;
    if ({a_busy, a_ready, a_done, a_timeout} !== 4'b1100) begin
      failures++;
      $display("FAIL no_watchdog busy/rdy/done/to: got %b%b%b%b want 1100",
               a_busy, a_ready, a_done, a_timeout);
    end
    $display("no watchdog: still busy after %0d idle cycles", n);
    rst = 1'b1;
    step();
    rst = 1'b0;
`endif
  endtask

  initial begin
    rst     = 1'b1;
    a_start = 1'b0;
    a_valid = 1'b0;
    a_data  = 8'h00;
    b_start = 1'b0;
    b_valid = 1'b0;
    b_data  = 8'h00;
    test_reset();
    test_clean();
    test_gaps();
    test_ignored();
    test_reset_mid_run();
    test_saturation();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: bench did not finish within 200000 time units");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/stream_checker.md
# stream_checker

Self-checking response monitor for the design's 8-bit data output port. It accepts an 8-bit word stream under a valid/ready handshake and compares each word against a PRBS-8 sequence seeded from a parameter. After a fixed word count it reports pass/fail and an error count. It sits on the output side of the device, opposite the stimulus driver that feeds `DATA_I`, so a test completes without a human reading `$display` output.

## Interface
- `P_WORDS`, 16: words checked per run (1..255).
- `P_SEED`, 8'h55: first expected word and LFSR seed. A value of 0 is replaced by 8'h01.
- `P_TIMEOUT`, 1024: idle-cycle limit. Used only with `STREAM_CHECKER_TIMEOUT_EN`.
- `CLK_I` in 1: clock, rising edge.
- `RST_I` in 1: reset, **synchronous and active-high**.
- `START_I` in 1: starts a run. Honoured in IDLE and DONE only.
- `DATA_I` in 8: word under test.
- `VALID_I` in 1: `DATA_I` is valid.
- `READY_O` out 1: checker can accept a word.
- `BUSY_O` out 1: state is RUN.
- `DONE_O` out 1: run finished. Level, held until the next start or reset.
- `PASS_O` out 1: run finished with zero errors and no timeout.
- `ERR_CNT_O` out 8: number of mismatches, saturating at 255.
- `FIRST_ERR_O` out 8: index (0-based) of the first mismatching word. 8'hFF if there was none.
- `TIMEOUT_O` out 1: run ended by the watchdog.

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE → RUN** on `START_I`.
  - On entry: word counter=0, `ERR_CNT_O`=0, `FIRST_ERR_O`=8'hFF, expected=seed, watchdog=0.
- **RUN:**
  - `READY_O`=1 and `BUSY_O`=1.
  - A word is accepted when `VALID_I && READY_O`.
  - On acceptance: if `DATA_I` != expected, `ERR_CNT_O` increments (saturating). On the first mismatch of the run, `FIRST_ERR_O` is also loaded with the word index.
  - On every acceptance, expected advances and the word counter increments.
- **LFSR:** next = {cur[6:0], cur[7]^cur[5]^cur[4]^cur[3]}.
  - It advances only on an accepted word. `VALID_I` without an accept has no effect.
- **RUN → DONE** on acceptance of word `P_WORDS`-1.
- **DONE:**
  - `READY_O`=0 and `DONE_O`=1.
  - `PASS_O` = (`ERR_CNT_O`==0) && !`TIMEOUT_O`.
  - `START_I` begins a new run, re-entering RUN with cleared state.
- `START_I` during RUN is ignored.
- `VALID_I` outside RUN is ignored, and no word is consumed.
- **Reset values:** state=IDLE; `READY_O`, `BUSY_O`, `DONE_O`, `PASS_O`, `TIMEOUT_O`=0; `ERR_CNT_O`=0; `FIRST_ERR_O`=8'hFF.
- **Reset mid-run:** the run is abandoned and state returns to IDLE with reset values. No partial result is reported.
- **`START_I` and reset in the same cycle:** reset wins.

## Timing
- `READY_O` rises the cycle after `START_I` is sampled. This is one cycle of latency to RUN.
- A mismatch is visible on `ERR_CNT_O` in the cycle after the accepting edge.
- `DONE_O` and `PASS_O` are valid in the cycle after the final accept. `READY_O` falls in that same cycle.
- Full throughput: one word per cycle while `VALID_I` is held high.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Configuration
- **`STREAM_CHECKER_TIMEOUT_EN` defined:**
  - In RUN, the watchdog counts consecutive cycles with no accept and clears on every accept.
  - When it reaches `P_TIMEOUT`: go to DONE with `TIMEOUT_O`=1 and `PASS_O`=0. `ERR_CNT_O` and `FIRST_ERR_O` are kept.
- **Not defined:** no watchdog logic is built, `TIMEOUT_O` is tied 0, and RUN waits indefinitely.

## Structure
- Package `stream_checker_pkg` holds:
  - the state enum;
  - the tap constant and an LFSR next-value function;
  - the seed-fixup function that maps 0 to 8'h01.
- One sub-module, `prbs8_gen`, provides:
  - inputs: load, advance, seed;
  - output: current value.
  - It is reusable by the stimulus side to generate the same stream.

## Test plan
- **Clean run:** `P_SEED`=8'h55, `P_WORDS`=4; drive 55, AB, 57, AF back-to-back.
  - Expect `DONE_O`=1, `PASS_O`=1, `ERR_CNT_O`=0, `FIRST_ERR_O`=FF one cycle after the 4th accept.
- **Single error with gaps:** same run, but the 3rd word is 8'h00 and `VALID_I` is low for 2 cycles between words 1 and 2.
  - Expect `ERR_CNT_O`=1, `FIRST_ERR_O`=2, `PASS_O`=0.
  - Expect the expected sequence unchanged by the gaps.
- **Saturation:** `P_WORDS`=255 with a zero stream, then a restart.
  - Expect `ERR_CNT_O`=255 and `FIRST_ERR_O`=0.
  - `START_I` in DONE must clear both, and a clean second run must pass.
- **Reset mid-run:** pulse `RST_I` after 2 accepts.
  - Expect `READY_O`=0, `DONE_O`=0, `FIRST_ERR_O`=FF next cycle.
  - A new `START_I` must restart from seed 55.
- **Ignored inputs:** `START_I` asserted during RUN, and `VALID_I` with data in IDLE.
  - Expect neither the counter nor the LFSR to change.
- **Timeout (macro on):** `P_TIMEOUT`=8; accept 1 word, then hold `VALID_I` low.
  - Expect DONE with `TIMEOUT_O`=1 and `PASS_O`=0.
  - With the macro off, the checker stays in RUN with `BUSY_O`=1.
